// File: rtl/ysyx_23060061_ifu_if.sv
// ---------------------------------------------------------------------------
// ysyx_23060061_ifu_if
// Bundles every handshake/bus signal of the instruction fetch unit.
//   PC channel    : pc_valid, pc_in, pc_ready       (core -> IFU next-PC offer)
//   Redirect      : flush, flush_pc                 (overrides pc_valid)
//   Read request  : mem_arvalid, mem_araddr, mem_arready
//   Read response : mem_rvalid, mem_rdata, mem_rresp, mem_rready
//   Instruction   : inst_valid, inst, inst_pc, fault, inst_ready
//   Debug         : dbg_state (encoded FSM state of the IFU)
// Handshake rule, all channels: a transfer happens in a cycle where both
// valid and ready are high at the rising clock edge; once valid is raised,
// it and its payload stay unchanged until that transfer.
// master = IFU side, slave = environment (core + memory) side.
// ---------------------------------------------------------------------------
interface ysyx_23060061_ifu_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              pc_valid;
    logic [ADDR_W-1:0] pc_in;
    logic              pc_ready;
    logic              flush;
    logic [ADDR_W-1:0] flush_pc;
    logic              mem_arvalid;
    logic [ADDR_W-1:0] mem_araddr;
    logic              mem_arready;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic [1:0]        mem_rresp;
    logic              mem_rready;
    logic              inst_valid;
    logic [DATA_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_ready;
    logic              fault;
    logic [2:0]        dbg_state;

    modport master (
        input  pc_valid, pc_in, flush, flush_pc,
        input  mem_arready, mem_rvalid, mem_rdata, mem_rresp, inst_ready,
        output pc_ready, mem_arvalid, mem_araddr, mem_rready,
        output inst_valid, inst, inst_pc, fault, dbg_state
    );

    modport slave (
        output pc_valid, pc_in, flush, flush_pc,
        output mem_arready, mem_rvalid, mem_rdata, mem_rresp, inst_ready,
        input  pc_ready, mem_arvalid, mem_araddr, mem_rready,
        input  inst_valid, inst, inst_pc, fault, dbg_state
    );
endinterface

// File: rtl/ysyx_23060061_ifu.sv
// ---------------------------------------------------------------------------
// ysyx_23060061_ifu
// Instruction fetch unit feeding the single-cycle core. Issues one 32-bit
// read per fetch PC, holds the instruction until the core takes it, then
// waits for the next PC. A flush redirects fetch and discards any in-flight
// read (exactly one read is ever outstanding).
// Ports:
//   clk  - clock
//   rst  - asynchronous active-high reset; restarts fetch at RESET_PC
//   bus  - ysyx_23060061_ifu_if.master (PC, flush, AR/R bus, inst, debug)
// Optional build macro:
//   YSYX_23060061_IFU_MISALIGN_CHECK_EN - a fetch target with addr[1:0]!=0
//   issues no bus request and is returned as a faulting NOP (0x00000013).
// ---------------------------------------------------------------------------
module ysyx_23060061_ifu #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h80000000
) (
    input logic                   clk,
    input logic                   rst,
    ysyx_23060061_ifu_if.master   bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        HOLD  = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              flush_pend_q, flush_pend_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic [DATA_W-1:0] inst_q, inst_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic              fault_q, fault_d;

    // A new fetch target chosen this cycle; resolved into REQ (or a
    // misalign fault) in one place at the end of the next-state logic.
    logic              take;
    logic [ADDR_W-1:0] tgt;

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        flush_pend_d = flush_pend_q;
        pend_pc_d    = pend_pc_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        fault_d      = fault_q;
        take         = 1'b0;
        tgt          = '0;

        case (state_q)
            IDLE: begin
                if (bus.flush) begin
                    take = 1'b1;
                    tgt  = bus.flush_pc;
                end else if (bus.pc_valid) begin
                    take = 1'b1;
                    tgt  = bus.pc_in;
                end
            end
            REQ: begin
                // The request cannot be withdrawn, so a flush is only
                // remembered; the address stays put until arready.
                if (bus.flush) begin
                    flush_pend_d = 1'b1;
                    pend_pc_d    = bus.flush_pc;
                end
                if (bus.mem_arready) begin
                    state_d = (flush_pend_q || bus.flush) ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                if (bus.flush && bus.mem_rvalid) begin
                    take = 1'b1;
                    tgt  = bus.flush_pc;
                end else if (bus.flush) begin
                    flush_pend_d = 1'b1;
                    pend_pc_d    = bus.flush_pc;
                    state_d      = DRAIN;
                end else if (bus.mem_rvalid) begin
                    inst_d    = bus.mem_rdata;
                    inst_pc_d = fetch_pc_q;
                    fault_d   = (bus.mem_rresp != 2'b00);
                    state_d   = HOLD;
                end
            end
            DRAIN: begin
                if (bus.flush) begin
                    pend_pc_d = bus.flush_pc;
                end
                if (bus.mem_rvalid) begin
                    flush_pend_d = 1'b0;
                    take         = 1'b1;
                    tgt          = bus.flush ? bus.flush_pc : pend_pc_q;
                end
            end
            HOLD: begin
                if (bus.flush) begin
                    take = 1'b1;
                    tgt  = bus.flush_pc;
                end else if (bus.inst_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = REQ;
            end
        endcase

        if (take) begin
            fetch_pc_d = tgt;
            state_d    = REQ;
`ifdef YSYX_23060061_IFU_MISALIGN_CHECK_EN
            if (tgt[1:0] != 2'b00) begin
                fetch_pc_d = fetch_pc_q;
                inst_d     = DATA_W'(32'h00000013);
                inst_pc_d  = tgt;
                fault_d    = 1'b1;
                state_d    = HOLD;
            end
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= REQ;
            fetch_pc_q   <= RESET_PC;
            flush_pend_q <= 1'b0;
            pend_pc_q    <= '0;
            inst_q       <= '0;
            inst_pc_q    <= '0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            flush_pend_q <= flush_pend_d;
            pend_pc_q    <= pend_pc_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            fault_q      <= fault_d;
        end
    end

    // All handshake outputs are pure decodes of the state register.
    assign bus.mem_arvalid = (state_q == REQ);
    assign bus.mem_araddr  = fetch_pc_q;
    assign bus.mem_rready  = (state_q == WAIT) || (state_q == DRAIN);
    assign bus.inst_valid  = (state_q == HOLD);
    assign bus.pc_ready    = (state_q == IDLE);
    assign bus.inst        = inst_q;
    assign bus.inst_pc     = inst_pc_q;
    assign bus.fault       = fault_q;
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_ysyx_23060061_ifu.sv
module tb_ysyx_23060061_ifu;
  logic clk = 1'b0;
  logic rst;

  ysyx_23060061_ifu_if bus ();

  ysyx_23060061_ifu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_ar_q[$];    // expected read addresses, in order
  logic [64:0] exp_inst_q[$];  // expected {fault, inst_pc, inst}

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_arvalid && bus.mem_arready) begin
        if (exp_ar_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ar_unexpected: got %h expected none", bus.mem_araddr);
        end else begin
          check("araddr", 65'(bus.mem_araddr), 65'(exp_ar_q.pop_front()));
        end
      end
      if (bus.inst_valid) begin
        check("pc_ready_in_hold", 65'(bus.pc_ready), 65'd0);
        if (exp_inst_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL inst_unexpected: got %h expected none", bus.inst);
        end else begin
          check("inst", {bus.fault, bus.inst_pc, bus.inst}, exp_inst_q[0]);
          if (bus.inst_ready || bus.flush) void'(exp_inst_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_fetch(input logic [31:0] d, input logic [1:0] resp, input logic [31:0] pc);
    bus.mem_arready = 1'b1;
    tick();
    bus.mem_arready = 1'b0;
    exp_inst_q.push_back({(resp != 2'b00), pc, d});
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = d;
    bus.mem_rresp  = resp;
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_rresp  = 2'b00;
  endtask

  task automatic accept_and_next(input logic [31:0] next_pc);
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    check("pc_ready_idle", 65'(bus.pc_ready), 65'd1);
    bus.pc_valid = 1'b1;
    bus.pc_in    = next_pc;
    exp_ar_q.push_back(next_pc);
    tick();
    bus.pc_valid = 1'b0;
    check("arvalid_after_pc", 65'(bus.mem_arvalid), 65'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst             = 1'b1;
    bus.pc_valid    = 1'b0;
    bus.pc_in       = '0;
    bus.flush       = 1'b0;
    bus.flush_pc    = '0;
    bus.mem_arready = 1'b0;
    bus.mem_rvalid  = 1'b0;
    bus.mem_rdata   = '0;
    bus.mem_rresp   = 2'b00;
    bus.inst_ready  = 1'b0;
    repeat (2) tick();

    // reset state
    check("rst_arvalid", 65'(bus.mem_arvalid), 65'd1);
    check("rst_araddr", 65'(bus.mem_araddr), 65'h80000000);
    check("rst_rready", 65'(bus.mem_rready), 65'd0);
    check("rst_inst_valid", 65'(bus.inst_valid), 65'd0);
    check("rst_inst", {bus.fault, bus.inst_pc, bus.inst}, 65'd0);
    check("rst_pc_ready", 65'(bus.pc_ready), 65'd0);

    // first fetch right after reset release
    exp_ar_q.push_back(32'h80000000);
    rst = 1'b0;
    do_fetch(32'h00100093, 2'b00, 32'h80000000);

    // core backpressure: monitor re-checks inst each held cycle
    repeat (5) tick();
    accept_and_next(32'h80000004);

    // flush in WAIT, stale response two cycles later
    bus.mem_arready = 1'b1;
    tick();
    bus.mem_arready = 1'b0;
    bus.flush    = 1'b1;
    bus.flush_pc = 32'h80000100;
    tick();
    bus.flush = 1'b0;
    check("drain_rready", 65'(bus.mem_rready), 65'd1);
    tick();
    exp_ar_q.push_back(32'h80000100);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hDEADBEEF;
    tick();
    bus.mem_rvalid = 1'b0;
    check("stale_no_inst", 65'(bus.inst_valid), 65'd0);
    check("redirect_araddr", 65'(bus.mem_araddr), 65'h80000100);
    do_fetch(32'h00200113, 2'b00, 32'h80000100);
    accept_and_next(32'h80000108);

    // two flushes in REQ while arready=0: address must not move
    bus.flush    = 1'b1;
    bus.flush_pc = 32'h80000180;
    tick();
    bus.flush_pc = 32'h80000200;
    tick();
    bus.flush = 1'b0;
    check("req_flush_arvalid", 65'(bus.mem_arvalid), 65'd1);
    check("req_flush_araddr", 65'(bus.mem_araddr), 65'h80000108);
    bus.mem_arready = 1'b1;
    tick();
    bus.mem_arready = 1'b0;
    check("drain_rready2", 65'(bus.mem_rready), 65'd1);
    exp_ar_q.push_back(32'h80000200);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h0BAD0BAD;
    tick();
    bus.mem_rvalid = 1'b0;
    check("drain_no_inst", 65'(bus.inst_valid), 65'd0);

    // error response, then flush while holding it
    do_fetch(32'h12345678, 2'b10, 32'h80000200);
    bus.flush    = 1'b1;
    bus.flush_pc = 32'h80000300;
    exp_ar_q.push_back(32'h80000300);
    tick();
    bus.flush = 1'b0;
    check("hold_flush_drop", 65'(bus.inst_valid), 65'd0);

    // flush and response in the same WAIT cycle
    bus.mem_arready = 1'b1;
    tick();
    bus.mem_arready = 1'b0;
    bus.flush      = 1'b1;
    bus.flush_pc   = 32'h80000400;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'hCAFEF00D;
    exp_ar_q.push_back(32'h80000400);
    tick();
    bus.flush      = 1'b0;
    bus.mem_rvalid = 1'b0;
    check("same_cycle_no_inst", 65'(bus.inst_valid), 65'd0);
    check("same_cycle_araddr", 65'(bus.mem_araddr), 65'h80000400);
    do_fetch(32'h00300193, 2'b00, 32'h80000400);
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;

    // misaligned PC from IDLE
    bus.pc_valid = 1'b1;
    bus.pc_in    = 32'h80000002;
`ifdef YSYX_23060061_IFU_MISALIGN_CHECK_EN
    exp_inst_q.push_back({1'b1, 32'h80000002, 32'h00000013});
    tick();
    bus.pc_valid = 1'b0;
    check("misalign_no_arvalid", 65'(bus.mem_arvalid), 65'd0);
`else
    exp_ar_q.push_back(32'h80000002);
    tick();
    bus.pc_valid = 1'b0;
    check("misalign_araddr", 65'(bus.mem_araddr), 65'h80000002);
    do_fetch(32'h00400213, 2'b00, 32'h80000002);
`endif
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;

    // reset mid-operation
    bus.pc_valid = 1'b1;
    bus.pc_in    = 32'h80000500;
    tick();
    bus.pc_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rerst_arvalid", 65'(bus.mem_arvalid), 65'd1);
    check("rerst_araddr", 65'(bus.mem_araddr), 65'h80000000);
    check("rerst_inst_valid", 65'(bus.inst_valid), 65'd0);
    tick();

    check("ar_queue_empty", 65'(exp_ar_q.size()), 65'd0);
    check("inst_queue_empty", 65'(exp_inst_q.size()), 65'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
